// File: rtl/race_seq.sv
// race_seq -- top-level race sequencer.
//
// Owns the car controller's lifecycle: holds it in reset through IDLE and the
// start countdown, passes player keys only while racing, counts laps from the
// car position with a checkpoint rule, and runs a saturating race clock in
// seconds. Every output is a register so the HUD sees clean values.
//
// Ports:
//   pclk       in   1   pixel clock, the only clock
//   rst_n      in   1   asynchronous active-low reset
//   start      in   1   level request to start / restart the race
//   key_in     in   4   raw player keys (UP=0001 DOWN=0010 LEFT=0100 RIGHT=1000)
//   xpos/ypos  in  11   car top-left position from the car controller
//   car_rst    out  1   active-high reset into the car controller
//   key_out    out  4   gated keys into the car controller
//   state      out  2   IDLE=00 COUNTDOWN=01 RACE=10 FINISH=11
//   count_val  out  2   countdown seconds remaining
//   lap        out  3   completed laps
//   race_secs  out 10   elapsed race seconds, saturating at 999
//   finished   out  1   high in FINISH
module race_seq #(
  parameter int TICK_DIV       = 65000000,
  parameter int COUNTDOWN_SECS = 3,
  parameter int LAPS           = 3,
  parameter int START_X0       = 400,
  parameter int START_X1       = 416,
  parameter int START_Y0       = 16,
  parameter int START_Y1       = 160,
  parameter int CP_X0          = 400,
  parameter int CP_X1          = 416,
  parameter int CP_Y0          = 608,
  parameter int CP_Y1          = 752
) (
  input  logic        pclk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [3:0]  key_in,
  input  logic [10:0] xpos,
  input  logic [10:0] ypos,
  output logic        car_rst,
  output logic [3:0]  key_out,
  output logic [1:0]  state,
  output logic [1:0]  count_val,
  output logic [2:0]  lap,
  output logic [9:0]  race_secs,
  output logic        finished
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [9:0] SECS_MAX = 10'd999;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_COUNT  = 2'b01,
    S_RACE   = 2'b10,
    S_FINISH = 2'b11
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [TW-1:0]   r_tick, w_tick_nxt;
  logic [1:0]      r_count, w_count_nxt;
  logic [2:0]      r_lap, w_lap_nxt;
  logic [9:0]      r_secs, w_secs_nxt;
  logic            r_cp_seen, w_cp_nxt;
  logic            r_in_start_d;
  logic            r_car_rst, w_car_rst_nxt;
  logic [3:0]      r_key, w_key_nxt;
  logic            r_finished, w_fin_nxt;

  logic            w_tick;
  logic [10:0]     w_cx, w_cy;
  logic            w_in_start, w_in_cp, w_lap_evt;
  logic [2:0]      w_lap_inc;

  // Car reference point is the sprite centre (64x64 sprite).
  assign w_cx = xpos + 11'd32;
  assign w_cy = ypos + 11'd32;

  assign w_in_start = (w_cx >= 11'(START_X0)) && (w_cx <= 11'(START_X1)) &&
                      (w_cy >= 11'(START_Y0)) && (w_cy <= 11'(START_Y1));
  assign w_in_cp    = (w_cx >= 11'(CP_X0)) && (w_cx <= 11'(CP_X1)) &&
                      (w_cy >= 11'(CP_Y0)) && (w_cy <= 11'(CP_Y1));

  assign w_tick    = (r_tick == TW'(TICK_DIV - 1));
  // A lap only counts on entering the start zone after the checkpoint was
  // visited; in_start_d runs in every state so a car parked on the line at
  // race start produces no edge.
  assign w_lap_evt = w_in_start && !r_in_start_d && r_cp_seen;
  assign w_lap_inc = r_lap + 3'd1;

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_lap_nxt   = r_lap;
    w_secs_nxt  = r_secs;
    w_cp_nxt    = r_cp_seen;

    case (r_state)
      S_IDLE, S_FINISH: begin
        if (start) begin
          w_state_nxt = S_COUNT;
          w_count_nxt = 2'(COUNTDOWN_SECS);
          w_lap_nxt   = 3'd0;
          w_secs_nxt  = 10'd0;
          w_cp_nxt    = 1'b0;
        end
      end
      S_COUNT: begin
        if (w_tick) begin
          if (r_count == 2'd1) begin
            w_state_nxt = S_RACE;
            w_count_nxt = 2'd0;
          end else begin
            w_count_nxt = r_count - 2'd1;
          end
        end
      end
      S_RACE: begin
        if (w_tick && (r_secs != SECS_MAX))
          w_secs_nxt = r_secs + 10'd1;
        // Lap event wins over a simultaneous checkpoint hit.
        if (w_lap_evt) begin
          w_lap_nxt = w_lap_inc;
          w_cp_nxt  = 1'b0;
          if (w_lap_inc == 3'(LAPS))
            w_state_nxt = S_FINISH;
        end else if (w_in_cp) begin
          w_cp_nxt = 1'b1;
        end
      end
      default: ;
    endcase

    // Tick phase restarts on every state change so each second is full length.
    if ((w_state_nxt != r_state) || w_tick)
      w_tick_nxt = '0;
    else
      w_tick_nxt = r_tick + 1'b1;

    // Registered outputs follow the state being entered so they line up
    // with the state output in the same cycle.
    w_car_rst_nxt = (w_state_nxt == S_IDLE) || (w_state_nxt == S_COUNT);
    w_key_nxt     = (w_state_nxt == S_RACE) ? key_in : 4'b0000;
    w_fin_nxt     = (w_state_nxt == S_FINISH);
  end

  // State and output registers
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_tick       <= '0;
      r_count      <= 2'd0;
      r_lap        <= 3'd0;
      r_secs       <= 10'd0;
      r_cp_seen    <= 1'b0;
      r_in_start_d <= 1'b0;
      r_car_rst    <= 1'b1;
      r_key        <= 4'b0000;
      r_finished   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_tick       <= w_tick_nxt;
      r_count      <= w_count_nxt;
      r_lap        <= w_lap_nxt;
      r_secs       <= w_secs_nxt;
      r_cp_seen    <= w_cp_nxt;
      r_in_start_d <= w_in_start;
      r_car_rst    <= w_car_rst_nxt;
      r_key        <= w_key_nxt;
      r_finished   <= w_fin_nxt;
    end
  end

  assign state     = r_state;
  assign count_val = r_count;
  assign lap       = r_lap;
  assign race_secs = r_secs;
  assign car_rst   = r_car_rst;
  assign key_out   = r_key;
  assign finished  = r_finished;

endmodule

// File: tb/tb_race_seq.sv
// tb_race_seq -- scoreboard bench for race_seq.
// The stimulus process drives directed vectors and pushes expected values,
// each tagged with the cycle at which it must hold; a separate monitor pops
// and compares them on the falling clock edge.
module tb_race_seq;

  logic        pclk;
  logic        rst_n;
  logic        start;
  logic [3:0]  key_in;
  logic [10:0] xpos;
  logic [10:0] ypos;
  logic        car_rst;
  logic [3:0]  key_out;
  logic [1:0]  state;
  logic [1:0]  count_val;
  logic [2:0]  lap;
  logic [9:0]  race_secs;
  logic        finished;

  race_seq #(.TICK_DIV(10)) dut (
    .pclk(pclk), .rst_n(rst_n), .start(start), .key_in(key_in),
    .xpos(xpos), .ypos(ypos), .car_rst(car_rst), .key_out(key_out),
    .state(state), .count_val(count_val), .lap(lap),
    .race_secs(race_secs), .finished(finished)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  localparam int SIG_STATE = 0, SIG_COUNT = 1, SIG_LAP = 2, SIG_SECS = 3,
                 SIG_FIN = 4, SIG_CRST = 5, SIG_KEY = 6;

  // Car positions (top-left) giving the centre points used by the test plan.
  localparam logic [10:0] X_LANE  = 11'd376;  // cx = 408
  localparam logic [10:0] Y_START = 11'd68;   // cy = 100
  localparam logic [10:0] Y_CP    = 11'd668;  // cy = 700
  localparam logic [10:0] Y_OUT   = 11'd368;  // cy = 400

  typedef struct {
    int    cyc;
    int    sig;
    int    exp;
    string name;
  } chk_t;

  chk_t sb[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  always @(posedge pclk) cyc <= cyc + 1;

  function automatic int actual(input int sig);
    case (sig)
      SIG_STATE: return int'(state);
      SIG_COUNT: return int'(count_val);
      SIG_LAP:   return int'(lap);
      SIG_SECS:  return int'(race_secs);
      SIG_FIN:   return int'(finished);
      SIG_CRST:  return int'(car_rst);
      SIG_KEY:   return int'(key_out);
      default:   return -1;
    endcase
  endfunction

  // Monitor: compare every entry whose cycle has arrived.
  always @(negedge pclk) begin : monitor
    int i;
    int a;
    i = 0;
    while (i < sb.size()) begin
      if (sb[i].cyc <= cyc) begin
        n_chk++;
        a = actual(sb[i].sig);
        if (sb[i].cyc == cyc && a == sb[i].exp)
          n_pass++;
        else
          $display("FAIL %s @cyc %0d (due %0d): got %0d, want %0d",
                   sb[i].name, cyc, sb[i].cyc, a, sb[i].exp);
        sb.delete(i);
      end else begin
        i++;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge pclk);
      #1;
    end
  endtask

  task automatic exp_at(input int k, input int sig, input int val, input string nm);
    chk_t c;
    c.cyc  = cyc + k;
    c.sig  = sig;
    c.exp  = val;
    c.name = nm;
    sb.push_back(c);
  endtask

  task automatic do_lap(input int n);
    ypos = Y_CP;    step(2);
    ypos = Y_OUT;   step(2);
    ypos = Y_START; step(1);
    exp_at(0, SIG_LAP, n, "lap_count");
  endtask

  int e0, rs, fc, s0, secs_fin;

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    key_in = 4'b0000;
    xpos   = X_LANE;
    ypos   = Y_START;
    step(2);
    exp_at(0, SIG_STATE, 0, "rst_state");
    exp_at(0, SIG_CRST,  1, "rst_car_rst");
    exp_at(0, SIG_KEY,   0, "rst_key_out");
    exp_at(0, SIG_COUNT, 0, "rst_count");
    exp_at(0, SIG_LAP,   0, "rst_lap");
    exp_at(0, SIG_SECS,  0, "rst_secs");
    exp_at(0, SIG_FIN,   0, "rst_finished");
    rst_n = 1'b1;
    step(3);
    exp_at(0, SIG_STATE, 0, "idle_wait");

    // Start and countdown, with UP held the whole time.
    key_in = 4'b0001;
    start  = 1'b1;
    step(1);
    start = 1'b0;
    e0 = cyc;
    exp_at(0,  SIG_STATE, 1, "cd_enter");
    exp_at(0,  SIG_COUNT, 3, "cd_3");
    exp_at(0,  SIG_CRST,  1, "cd_car_rst");
    exp_at(0,  SIG_KEY,   0, "cd_key_gate");
    exp_at(9,  SIG_COUNT, 3, "cd_3_hold");
    exp_at(10, SIG_COUNT, 2, "cd_2");
    exp_at(15, SIG_KEY,   0, "cd_key_gate_mid");
    exp_at(19, SIG_COUNT, 2, "cd_2_hold");
    exp_at(20, SIG_COUNT, 1, "cd_1");
    exp_at(29, SIG_STATE, 1, "cd_last");
    exp_at(29, SIG_CRST,  1, "cd_last_car_rst");
    exp_at(30, SIG_STATE, 2, "race_enter");
    exp_at(30, SIG_CRST,  0, "race_car_rst");
    exp_at(30, SIG_COUNT, 0, "race_count0");
    exp_at(31, SIG_KEY,   1, "race_key_up");
    exp_at(31, SIG_LAP,   0, "race_lap0");
    step(31);
    rs = e0 + 30;

    // Parked on the start line at race start: no lap.
    step(3);
    exp_at(0, SIG_LAP, 0, "no_lap_at_start");
    key_in = 4'b0010;
    exp_at(1, SIG_KEY, 2, "race_key_down");
    step(1);

    // Shortcut: leave and re-enter start zone without the checkpoint.
    ypos = Y_OUT;   step(2);
    ypos = Y_START; step(2);
    exp_at(0, SIG_LAP, 0, "shortcut_lap");

    do_lap(1); step(2);
    do_lap(2); step(2);
    do_lap(3);
    fc = cyc;
    secs_fin = (fc - rs) / 10;
    exp_at(0,  SIG_STATE, 3, "fin_state");
    exp_at(0,  SIG_FIN,   1, "fin_flag");
    exp_at(0,  SIG_KEY,   0, "fin_key_gate");
    exp_at(0,  SIG_CRST,  0, "fin_car_rst");
    exp_at(0,  SIG_SECS,  secs_fin, "fin_secs");
    exp_at(25, SIG_SECS,  secs_fin, "fin_secs_frozen");
    exp_at(25, SIG_LAP,   3, "fin_lap_frozen");
    exp_at(25, SIG_STATE, 3, "fin_hold");
    exp_at(25, SIG_KEY,   0, "fin_key_hold");
    step(25);

    // Restart from FINISH.
    start = 1'b1;
    step(1);
    start = 1'b0;
    s0 = cyc;
    exp_at(0,  SIG_STATE, 1, "restart_state");
    exp_at(0,  SIG_LAP,   0, "restart_lap");
    exp_at(0,  SIG_SECS,  0, "restart_secs");
    exp_at(0,  SIG_COUNT, 3, "restart_count");
    exp_at(0,  SIG_FIN,   0, "restart_fin");
    exp_at(0,  SIG_CRST,  1, "restart_car_rst");
    exp_at(30, SIG_STATE, 2, "race2_enter");
    step(30);

    do_lap(1); step(2);
    do_lap(2);
    // Long enough for more than 999 ticks.
    step(10010);
    exp_at(0, SIG_SECS,  999, "secs_saturate");
    exp_at(0, SIG_LAP,   2,   "lap2_before_rst");
    exp_at(0, SIG_STATE, 2,   "race_before_rst");
    // Wait for those to be checked, then reset just after a rising edge:
    // values are sampled on the falling edge with no rising edge between.
    step(1);
    rst_n = 1'b0;
    exp_at(0, SIG_STATE, 0, "async_rst_state");
    exp_at(0, SIG_CRST,  1, "async_rst_car_rst");
    exp_at(0, SIG_LAP,   0, "async_rst_lap");
    exp_at(0, SIG_SECS,  0, "async_rst_secs");
    exp_at(0, SIG_KEY,   0, "async_rst_key");
    step(1);
    rst_n = 1'b1;
    step(5);
    exp_at(0, SIG_STATE, 0, "post_rst_idle");
    exp_at(0, SIG_CRST,  1, "post_rst_car_rst");
    step(2);

    if (sb.size() != 0) begin
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
      n_chk += sb.size();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
